// File: rtl/rtc_seq_pkg.sv
// Shared encodings for the RTC phase sequencer: state codes, bus-owner phase
// codes and the elaboration-time phase-counter width check.
package rtc_seq_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_READ  = 3'd1,
      ST_IDLE  = 3'd2,
      ST_EDIT  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   localparam logic [1:0] PH_INIT  = 2'd0;
   localparam logic [1:0] PH_READ  = 2'd1;
   localparam logic [1:0] PH_IDLE  = 2'd2;
   localparam logic [1:0] PH_WRITE = 2'd3;

   // True when a cnt_w-bit counter can reach every configured cycle count.
   function automatic bit cnt_w_ok(input int cnt_w, input int a, input int b,
                                   input int c, input int d);
      longint m;
      m = longint'(a);
      if (longint'(b) > m) m = longint'(b);
      if (longint'(c) > m) m = longint'(c);
      if (longint'(d) > m) m = longint'(d);
      return (cnt_w > 0) && (cnt_w < 62) && ((longint'(1) << cnt_w) > m);
   endfunction

endpackage

// File: rtl/rtc_seq_general_if.sv
// Request/strobe bundle between the RTC phase sequencer (slave) and the
// button/sub-FSM side (master).
interface rtc_seq_general_if #(parameter int N_MODES = 3);

   logic [N_MODES-1:0] mode_req;
   logic               wr_done;
   logic               do_it_inic;
   logic               do_it_leer;
   logic               do_it_esc;
   logic [1:0]         phase;
   logic [N_MODES-1:0] en_edit;
   logic [N_MODES-1:0] esc_sel;
   logic               ch0_mux2;
   logic               wr_timeout;

   modport master (
      output mode_req, wr_done,
      input  do_it_inic, do_it_leer, do_it_esc, phase, en_edit, esc_sel,
             ch0_mux2, wr_timeout
   );

   modport slave (
      input  mode_req, wr_done,
      output do_it_inic, do_it_leer, do_it_esc, phase, en_edit, esc_sel,
             ch0_mux2, wr_timeout
   );

endinterface

// File: rtl/rtc_seq_prio_enc.sv
// Lowest-index-wins priority encoder for the edit-mode requests.
module rtc_seq_prio_enc #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     oh,
   output logic             vld,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      oh  = '0;
      idx = '0;
      // Walk downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            oh     = '0;
            oh[i]  = 1'b1;
            idx    = IDX_W'(i);
         end
      end
      vld = |req;
   end

endmodule

// File: rtl/rtc_seq_general.sv
// Top-level phase sequencer for the RTC controller: INIT -> READ -> IDLE/EDIT
// -> WRITE. Optional macro SEQ_WR_HS_EN adds a wr_done handshake with watchdog.
module rtc_seq_general
   import rtc_seq_pkg::*;
#(
   parameter int N_MODES     = 3,
   parameter int INIT_CYC    = 518,
   parameter int READ_CYC    = 432,
   parameter int REFRESH_CYC = 1599570,
   parameter int WRITE_CYC   = 260,
   parameter int CNT_W       = 21
) (
   input  logic              clk,
   input  logic              reset,
   rtc_seq_general_if.slave  bus
);

   localparam int IDX_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;

   localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_CYC - 1);
   localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_CYC - 1);
   localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYC - 1);
   localparam logic [CNT_W-1:0] WRITE_LAST   = CNT_W'(WRITE_CYC - 1);

   if (!cnt_w_ok(CNT_W, INIT_CYC, READ_CYC, REFRESH_CYC, WRITE_CYC)) begin : g_bad_cnt_w
      $error("rtc_seq_general: CNT_W too narrow for the configured cycle counts");
   end

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   mode_lat;
   logic [N_MODES-1:0] lat_oh;

   logic [N_MODES-1:0] req_oh;
   logic               req_vld;
   logic [IDX_W-1:0]   req_idx;

   rtc_seq_prio_enc #(.N(N_MODES), .IDX_W(IDX_W)) u_prio (
      .req (bus.mode_req),
      .oh  (req_oh),
      .vld (req_vld),
      .idx (req_idx)
   );

`ifdef SEQ_WR_HS_EN
   logic to_set;
   logic wr_timeout_q;
`else
   logic unused_wr_done;
   assign unused_wr_done = bus.wr_done;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_INIT;
         cnt      <= '0;
         mode_lat <= '0;
         lat_oh   <= '0;
`ifdef SEQ_WR_HS_EN
         wr_timeout_q <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         if (state == ST_IDLE && req_vld) begin
            mode_lat <= req_idx;
            lat_oh   <= req_oh;
         end
`ifdef SEQ_WR_HS_EN
         if (to_set) wr_timeout_q <= 1'b1;
`endif
      end
   end

   always_comb begin
      state_nxt      = state;
`ifdef SEQ_WR_HS_EN
      to_set         = 1'b0;
`endif
      bus.do_it_inic = 1'b0;
      bus.do_it_leer = 1'b0;
      bus.do_it_esc  = 1'b0;
      bus.phase      = PH_INIT;
      bus.en_edit    = '0;
      bus.esc_sel    = '0;
      bus.ch0_mux2   = 1'b0;
      case (state)
         ST_INIT: begin
            bus.do_it_inic = 1'b1;
            if (cnt == INIT_LAST) state_nxt = ST_READ;
         end
         ST_READ: begin
            bus.do_it_leer = 1'b1;
            bus.phase      = PH_READ;
            if (cnt == READ_LAST) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            bus.phase = PH_IDLE;
            // A pending edit request beats a refresh expiring on the same cycle.
            if (req_vld)                  state_nxt = ST_EDIT;
            else if (cnt == REFRESH_LAST) state_nxt = ST_READ;
         end
         ST_EDIT: begin
            bus.phase    = PH_IDLE;
            bus.en_edit  = lat_oh;
            bus.ch0_mux2 = 1'b1;
            if (!bus.mode_req[mode_lat]) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            bus.do_it_esc = 1'b1;
            bus.esc_sel   = lat_oh;
            bus.phase     = PH_WRITE;
`ifdef SEQ_WR_HS_EN
            if (bus.wr_done) state_nxt = ST_READ;
            else if (cnt == WRITE_LAST) begin
               state_nxt = ST_READ;
               to_set    = 1'b1;
            end
`else
            if (cnt == WRITE_LAST) state_nxt = ST_READ;
`endif
         end
         default: state_nxt = ST_INIT;
      endcase
   end

`ifdef SEQ_WR_HS_EN
   assign bus.wr_timeout = wr_timeout_q;
`else
   assign bus.wr_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_seq_general.sv
// Scoreboard bench for rtc_seq_general: a phase/countdown reference model
// pushes the expected outputs every cycle; a negedge monitor compares them.
module tb_rtc_seq_general;

   localparam int N  = 3;
   localparam int IC = 8;
   localparam int RC = 5;
   localparam int FC = 20;
   localparam int WC = 4;
   localparam int CW = 5;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rtc_seq_general_if #(.N_MODES(N)) bus();

   rtc_seq_general #(
      .N_MODES(N), .INIT_CYC(IC), .READ_CYC(RC), .REFRESH_CYC(FC),
      .WRITE_CYC(WC), .CNT_W(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef enum {M_INIT, M_READ, M_IDLE, M_EDIT, M_WRITE} mph_t;
   mph_t mph  = M_INIT;
   int   left = 0;
   int   lat  = 0;
   bit   mto  = 1'b0;

   logic [12:0] exp_q[$];
   logic [12:0] mon_act, mon_exp;

   // Output vector: {inic, leer, esc, phase[1:0], en_edit[2:0], esc_sel[2:0], ch0_mux2, wr_timeout}
   function automatic logic [12:0] expect_of(input mph_t p, input int l, input bit t);
      logic [2:0] oh;
      oh = 3'(1 << l);
      case (p)
         M_INIT:  return {3'b100, 2'd0, 3'b000, 3'b000, 1'b0, t};
         M_READ:  return {3'b010, 2'd1, 3'b000, 3'b000, 1'b0, t};
         M_IDLE:  return {3'b000, 2'd2, 3'b000, 3'b000, 1'b0, t};
         M_EDIT:  return {3'b000, 2'd2, oh,     3'b000, 1'b1, t};
         default: return {3'b001, 2'd3, 3'b000, oh,     1'b0, t};
      endcase
   endfunction

   // Reference model: each phase holds a countdown of cycles still to spend.
   always @(posedge clk) begin
      if (!reset) begin
         mph = M_INIT; left = IC; lat = 0; mto = 1'b0;
      end else begin
         case (mph)
            M_INIT: begin
               left--;
               if (left == 0) begin mph = M_READ; left = RC; end
            end
            M_READ: begin
               left--;
               if (left == 0) begin mph = M_IDLE; left = FC; end
            end
            M_IDLE: begin
               if (bus.mode_req != 0) begin
                  for (int i = N - 1; i >= 0; i--) if (bus.mode_req[i]) lat = i;
                  mph = M_EDIT;
               end else begin
                  left--;
                  if (left == 0) begin mph = M_READ; left = RC; end
               end
            end
            M_EDIT: begin
               if (!bus.mode_req[lat]) begin mph = M_WRITE; left = WC; end
            end
            M_WRITE: begin
`ifdef SEQ_WR_HS_EN
               if (bus.wr_done) begin mph = M_READ; left = RC; end
               else begin
                  left--;
                  if (left == 0) begin mph = M_READ; left = RC; mto = 1'b1; end
               end
`else
               left--;
               if (left == 0) begin mph = M_READ; left = RC; end
`endif
            end
         endcase
      end
      exp_q.push_back(expect_of(mph, lat, mto));
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = {bus.do_it_inic, bus.do_it_leer, bus.do_it_esc, bus.phase,
                    bus.en_edit, bus.esc_sel, bus.ch0_mux2, bus.wr_timeout};
         checks++;
         if (mon_act !== mon_exp) begin
            failures++;
            if (failures <= 20)
               $display("FAIL outputs t=%0t act=%b exp=%b", $time, mon_act, mon_exp);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic wait_ph(input mph_t p, input int l, input int budget, input string nm);
      int k;
      k = 0;
      while (!(mph == p && (l < 0 || left == l)) && k < budget) begin
         step(1);
         k++;
      end
      if (!(mph == p && (l < 0 || left == l))) begin
         checks++;
         failures++;
         $display("FAIL timeout_%s act=%0d exp=%0d", nm, k, budget);
      end
   endtask

   initial begin
      bus.mode_req = '0;
      bus.wr_done  = 1'b0;
      step(3);
      reset = 1'b1;
      #3 chk("reset_inic", int'(bus.do_it_inic), 1);

      // Free-running refresh: no requests.
      step(100);

      // Two requests held: lowest index (1) is edited for 10 cycles.
      wait_ph(M_IDLE, -1, 200, "idle_a");
      bus.mode_req = 3'b110;
      step(1);
      #3 chk("edit_110_en", int'(bus.en_edit), 3'b010);
      chk("edit_110_ch0", int'(bus.ch0_mux2), 1);
      step(9);
      bus.mode_req = '0;
      step(1);
      #3 chk("write_110_sel", int'(bus.esc_sel), 3'b010);
      chk("write_110_phase", int'(bus.phase), 3);
      step(15);

      // Request lands on the last refresh-wait cycle: EDIT wins.
      wait_ph(M_IDLE, 1, 200, "idle_last");
      bus.mode_req = 3'b100;
      step(1);
      #3 chk("race_en_edit", int'(bus.en_edit), 3'b100);
      chk("race_phase", int'(bus.phase), 2);
      step(2);
      bus.mode_req = '0;
      step(12);

      // Other requests ignored in EDIT; the still-held one reopens EDIT later.
      wait_ph(M_IDLE, -1, 200, "idle_b");
      bus.mode_req = 3'b001;
      step(3);
      bus.mode_req = 3'b011;
      step(3);
      bus.mode_req = 3'b010;
      step(1);
      #3 chk("held_sel", int'(bus.esc_sel), 3'b001);
      wait_ph(M_IDLE, -1, 50, "idle_c");
      step(1);
      #3 chk("reopen_en", int'(bus.en_edit), 3'b010);
      bus.mode_req = '0;
      step(12);

      // Reset during WRITE cycle 2.
      wait_ph(M_IDLE, -1, 200, "idle_d");
      bus.mode_req = 3'b100;
      step(2);
      bus.mode_req = '0;
      wait_ph(M_WRITE, WC - 2, 50, "write_c2");
      reset = 1'b0;
      step(1);
      #3 chk("rst_wr_inic", int'(bus.do_it_inic), 1);
      chk("rst_wr_phase", int'(bus.phase), 0);
      chk("rst_wr_sel", int'(bus.esc_sel), 0);
      reset = 1'b1;
      step(20);

`ifdef SEQ_WR_HS_EN
      wait_ph(M_IDLE, -1, 200, "idle_hs");
      bus.mode_req = 3'b001;
      step(2);
      bus.mode_req = '0;
      wait_ph(M_WRITE, WC - 1, 50, "write_c1");
      bus.wr_done = 1'b1;
      step(1);
      bus.wr_done = 1'b0;
      #3 chk("hs_leer", int'(bus.do_it_leer), 1);
      chk("hs_no_to", int'(bus.wr_timeout), 0);
      wait_ph(M_IDLE, -1, 50, "idle_to");
      bus.mode_req = 3'b010;
      step(2);
      bus.mode_req = '0;
      wait_ph(M_READ, -1, 50, "read_to");
      #3 chk("hs_timeout", int'(bus.wr_timeout), 1);
      step(30);
`endif

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 11) == 0)
            bus.mode_req = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
         bus.wr_done = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         step(1);
      end
      reset = 1'b1;
      bus.mode_req = '0;
      bus.wr_done = 1'b0;
      step(2);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout act=%0t exp=finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rtc_seq_general.md
Name: rtc_seq_general

Overview:
- Top-level phase sequencer for the RTC controller.
- Drives the init, read and write sub-FSMs through one-hot do_it strobes.
- Selects which sub-FSM owns the shared bus via a phase code.
- Supports N_MODES user edit modes (hour/date/timer by default), each with a parametrised duration instead of hard-wired constants.

Parameters:
- N_MODES, 3, number of edit-mode request inputs; index 0 has highest priority.
- INIT_CYC, 518, cycles spent in INIT after reset.
- READ_CYC, 432, cycles per full read burst.
- REFRESH_CYC, 1599570, idle cycles between automatic reads (about 16 ms at 100 MHz).
- WRITE_CYC, 260, write-burst length; it is also the watchdog limit when SEQ_WR_HS_EN is defined.
- CNT_W, 21, phase counter width; must satisfy 2^CNT_W > max(all *_CYC); elaboration error otherwise.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-low reset.
- mode_req, in, N_MODES, level edit requests (debounced buttons).
- wr_done, in, 1, write sub-FSM completion pulse (used only with SEQ_WR_HS_EN).
- do_it_inic, out, 1, enable for the init sub-FSM.
- do_it_leer, out, 1, enable for the read sub-FSM.
- do_it_esc, out, 1, enable for the write sub-FSM.
- phase, out, 2, bus-owner select: 0 = INIT, 1 = READ, 2 = IDLE/EDIT, 3 = WRITE.
- en_edit, out, N_MODES, one-hot counter enable for the mode being edited.
- esc_sel, out, N_MODES, one-hot mode being written; drives estado_* of the write FSM.
- ch0_mux2, out, 1, selects edit counters onto the write data path.
- wr_timeout, out, 1, sticky watchdog flag (SEQ_WR_HS_EN only; otherwise tied 0).

Behaviour:
- States: INIT, READ, IDLE, EDIT, WRITE. Moore outputs, decoded from the state register only.
- Phase counter cnt clears on every state change and increments every cycle while in the same state.
- Reset: when reset==0 at a clk edge, the block loads state=INIT, cnt=0, mode_lat=0, wr_timeout=0. Outputs: do_it_inic=1, phase=0, every other output 0. Reset mid-burst aborts the burst and reruns the full INIT.
- INIT: lasts exactly INIT_CYC cycles (exit when cnt==INIT_CYC-1), then goes to READ.
- READ: do_it_leer=1, phase=1. Lasts exactly READ_CYC cycles, then goes to IDLE. mode_req is ignored during READ.
- IDLE: phase=2, all strobes 0. Transitions in priority order:
  - any mode_req bit set: latch the lowest set index into mode_lat; go to EDIT.
  - else cnt==REFRESH_CYC-1: go to READ.
  - A request wins over a refresh expiry that lands in the same cycle.
- EDIT: en_edit=onehot(mode_lat), ch0_mux2=1, phase=2. Stays until mode_req[mode_lat]==0, then goes to WRITE. Other request bits are ignored, both while in EDIT and while still held at exit. No timeout.
- WRITE: do_it_esc=1, esc_sel=onehot(mode_lat), phase=3. Lasts exactly WRITE_CYC cycles, then goes to READ so the display refreshes immediately.
- esc_sel is 0 in every state except WRITE.
- Illegal state encoding: the next state is INIT.

Optional Feature:
- Macro: SEQ_WR_HS_EN.
- Defined: WRITE exits to READ one cycle after wr_done==1 is sampled in WRITE. If cnt reaches WRITE_CYC-1 without wr_done, WRITE exits anyway and wr_timeout is set to 1; only reset clears it. wr_done outside WRITE is ignored.
- Undefined: fixed-length WRITE as above; wr_done is unused; wr_timeout is constant 0.

Decomposition:
- Package rtc_seq_pkg holds:
  - state encodings ST_INIT..ST_WRITE (3 bits);
  - phase codes PH_INIT/PH_READ/PH_IDLE/PH_WRITE;
  - the counter-width check function.
- Sub-module rtc_seq_prio_enc(N): mode_req in, lowest-index one-hot plus valid plus binary index out, purely combinational. Instantiated once.

Test Plan (all scenarios use N_MODES=3, INIT_CYC=8, READ_CYC=5, REFRESH_CYC=20, WRITE_CYC=4, CNT_W=5):
- Reset released at cycle 0 -> do_it_inic=1 for cycles 0-7; do_it_leer=1 for cycles 8-12; phase=2 from cycle 13; do_it_leer again at cycle 33.
- No requests for 100 cycles -> READ bursts recur every 25 cycles; 5-cycle pulses exactly.
- In IDLE, mode_req=3'b110 held 10 cycles, then 0 -> en_edit=3'b010 and ch0_mux2=1 for 10 cycles. Then WRITE: esc_sel=3'b010 and phase=3 for 4 cycles, then READ.
- mode_req[2] asserted on the exact cycle cnt==19 in IDLE -> goes to EDIT (not READ); en_edit=3'b100.
- In EDIT (mode 0), mode_req[1] asserted, then mode_req[0] dropped while [1] is still high -> WRITE with esc_sel=3'b001. On return to IDLE, mode_req[1] immediately opens EDIT with en_edit=3'b010.
- Reset pulled low during WRITE cycle 2 -> next cycle is INIT with all outputs at reset values.
  - SEQ_WR_HS_EN variant: wr_done on WRITE cycle 1 -> READ on the next cycle. No wr_done -> exit after 4 cycles with wr_timeout=1, held until reset.
